// File: rtl/split_merge_task_seq_pkg.sv
// Shared definitions for the split/merge chain sequencer: widths, task types, FSM states, task word layout.
package split_merge_task_seq_pkg;

   localparam int MEM_ADDR_BITS  = 12;
   localparam int TASK_REDUCE_BW = 3 * MEM_ADDR_BITS + 16;

   typedef logic [MEM_ADDR_BITS-1:0] mem_addr_t;

   localparam logic [2:0] SM_SPLIT_256 = 3'd2;
   localparam logic [2:0] SM_MERGE_256 = 3'd3;
   localparam logic [2:0] SM_SPLIT_512 = 3'd4;
   localparam logic [2:0] SM_MERGE_512 = 3'd5;

   typedef enum logic [2:0] {
      SM_IDLE  = 3'd0,
      SM_CHECK = 3'd1,
      SM_ISSUE = 3'd2,
      SM_WAIT  = 3'd3,
      SM_FIN   = 3'd4
   } sm_seq_state_t;

   typedef struct packed {
      mem_addr_t  addr0;
      mem_addr_t  addr1;
      mem_addr_t  addr2;
      logic [4:0] stage;
      logic [2:0] task_type;
      logic [1:0] mode;
      logic       out_pos;
      logic       in_pos;
      logic [3:0] rsvd;
   } sm_task_t;

   function automatic logic [2:0] sm_type_sel(input logic merge, input logic n512);
      logic [2:0] t;
      case ({n512, merge})
         2'b00:   t = SM_SPLIT_256;
         2'b01:   t = SM_MERGE_256;
         2'b10:   t = SM_SPLIT_512;
         2'b11:   t = SM_MERGE_512;
         default: t = SM_SPLIT_256;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/split_merge_task_seq_if.sv
// Command and operator-task bus of the split/merge sequencer; slave is the sequencer's view.
interface split_merge_task_seq_if;
   import split_merge_task_seq_pkg::*;

   logic                      cmd_valid;
   logic                      cmd_ready;
   logic                      cmd_merge;
   logic                      cmd_n512;
   logic [4:0]                cmd_first_stage;
   logic [3:0]                cmd_num_stages;
   logic                      cmd_in_pos;
   logic                      cmd_out_pos;
   mem_addr_t                 cmd_src;
   mem_addr_t                 cmd_addr_a;
   mem_addr_t                 cmd_addr_b;
   mem_addr_t                 cmd_side;
   logic [TASK_REDUCE_BW-1:0] task_o;
   logic                      start_o;
   logic                      done_i;
   logic                      busy_o;
   logic                      done_o;
   logic                      err_o;

   modport master (
      output cmd_valid, cmd_merge, cmd_n512, cmd_first_stage, cmd_num_stages,
             cmd_in_pos, cmd_out_pos, cmd_src, cmd_addr_a, cmd_addr_b, cmd_side, done_i,
      input  cmd_ready, task_o, start_o, busy_o, done_o, err_o
   );

   modport slave (
      input  cmd_valid, cmd_merge, cmd_n512, cmd_first_stage, cmd_num_stages,
             cmd_in_pos, cmd_out_pos, cmd_src, cmd_addr_a, cmd_addr_b, cmd_side, done_i,
      output cmd_ready, task_o, start_o, busy_o, done_o, err_o
   );

endinterface

// File: rtl/split_merge_task_seq_task_pack.sv
// Combinational packing of one split/merge exec task into the operator task word.
module sm_task_pack
   import split_merge_task_seq_pkg::*;
(
   input  logic [4:0]                stage,
   input  logic [2:0]                task_type,
   input  logic                      in_pos,
   input  logic                      out_pos,
   input  mem_addr_t                 addr0,
   input  mem_addr_t                 addr1,
   input  mem_addr_t                 addr2,
   output logic [TASK_REDUCE_BW-1:0] task_word
);

   sm_task_t task_s;

   // Field assembly; mode stays 0 (fft mode) and unused bits stay 0.
   always_comb begin
      task_s           = '0;
      task_s.addr0     = addr0;
      task_s.addr1     = addr1;
      task_s.addr2     = addr2;
      task_s.stage     = stage;
      task_s.task_type = task_type;
      task_s.mode      = 2'b00;
      task_s.out_pos   = out_pos;
      task_s.in_pos    = in_pos;
      task_word        = task_s;
   end

endmodule

// File: rtl/split_merge_task_seq.sv
// Split/merge chain sequencer: one command becomes a chain of exec tasks with ping-pong buffers.
// Optional busy-cycle counter output perf_cycles when SPLIT_MERGE_SEQ_PERF_EN is defined.
module split_merge_task_seq
   import split_merge_task_seq_pkg::*;
#(
   parameter int SIDE_STRIDE = 64,
   parameter int MAX_STAGE   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   split_merge_task_seq_if.slave   bus
`ifdef SPLIT_MERGE_SEQ_PERF_EN
   ,
   output logic [31:0]             perf_cycles
`endif
);

   localparam mem_addr_t  STRIDE_W    = mem_addr_t'(SIDE_STRIDE);
   localparam logic [5:0] MAX_STAGE_W = 6'(MAX_STAGE);

   sm_seq_state_t             state_r, state_nx_s;
   logic                      merge_r, n512_r, in_pos_r, out_pos_r;
   logic [4:0]                first_r;
   logic [3:0]                num_r, k_r;
   mem_addr_t                 cur_r, a_r, b_r, side_r;
   logic [TASK_REDUCE_BW-1:0] task_r;
   logic                      start_r, busy_r, done_r, err_r, ready_r;

   logic [3:0]                k_nx_s, side_idx_s;
   mem_addr_t                 cur_nx_s, pp_s, pp_nx_s, side_addr_s, addr1_s, addr2_s;
   logic                      in_pos_nx_s, accept_s, reject_s, last_s;
   logic [5:0]                first6_s, nm1_s, min_s, max_s;
   logic [4:0]                stage_s;
   logic [TASK_REDUCE_BW-1:0] pack_s;

   assign accept_s = bus.cmd_valid & ready_r;
   assign last_s   = (k_r == (num_r - 4'd1));
   assign pp_s     = k_r[0] ? b_r : a_r;

   // Chain legality from the registered command, evaluated in CHECK.
   always_comb begin
      first6_s = {1'b0, first_r};
      nm1_s    = {2'b00, num_r} - 6'd1;
      if (merge_r) begin
         min_s = first6_s;
         max_s = first6_s + nm1_s;
      end else begin
         min_s = first6_s - nm1_s;
         max_s = first6_s;
      end
      reject_s = (num_r == 4'd0) || (num_r > 4'd9)
              || (!merge_r && (first6_s < nm1_s))
              || (max_s > MAX_STAGE_W)
              || (!n512_r && (min_s <= 6'd8) && (max_s >= 6'd8));
   end

   // Next-state and next chain position.
   always_comb begin
      state_nx_s  = state_r;
      k_nx_s      = k_r;
      cur_nx_s    = cur_r;
      in_pos_nx_s = in_pos_r;
      case (state_r)
         SM_IDLE: begin
            if (accept_s) begin
               state_nx_s  = SM_CHECK;
               k_nx_s      = 4'd0;
               cur_nx_s    = bus.cmd_src;
               in_pos_nx_s = bus.cmd_in_pos;
            end else begin
               state_nx_s  = SM_IDLE;
            end
         end
         SM_CHECK: begin
            if (reject_s) begin
               state_nx_s = SM_IDLE;
            end else begin
               state_nx_s = SM_ISSUE;
            end
         end
         SM_ISSUE: state_nx_s = SM_WAIT;
         SM_WAIT: begin
            if (bus.done_i) begin
               state_nx_s  = last_s ? SM_FIN : SM_ISSUE;
               k_nx_s      = k_r + 4'd1;
               cur_nx_s    = pp_s;
               in_pos_nx_s = out_pos_r;
            end else begin
               state_nx_s  = SM_WAIT;
            end
         end
         SM_FIN:  state_nx_s = SM_IDLE;
         default: state_nx_s = SM_IDLE;
      endcase
   end

   // Task fields for the task about to be issued (index k_nx_s).
   always_comb begin
      pp_nx_s     = k_nx_s[0] ? b_r : a_r;
      stage_s     = merge_r ? (first_r + {1'b0, k_nx_s}) : (first_r - {1'b0, k_nx_s});
      side_idx_s  = merge_r ? (num_r - 4'd1 - k_nx_s) : k_nx_s;
      side_addr_s = side_r + mem_addr_t'(side_idx_s) * STRIDE_W;
      if (merge_r) begin
         addr1_s = side_addr_s;
         addr2_s = pp_nx_s;
      end else begin
         addr1_s = pp_nx_s;
         addr2_s = side_addr_s;
      end
   end

   sm_task_pack u_pack (
      .stage     (stage_s),
      .task_type (sm_type_sel(merge_r, n512_r)),
      .in_pos    (in_pos_nx_s),
      .out_pos   (out_pos_r),
      .addr0     (cur_nx_s),
      .addr1     (addr1_s),
      .addr2     (addr2_s),
      .task_word (pack_s)
   );

   // State, command capture and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= SM_IDLE;
         merge_r   <= 1'b0;
         n512_r    <= 1'b0;
         in_pos_r  <= 1'b0;
         out_pos_r <= 1'b0;
         first_r   <= 5'd0;
         num_r     <= 4'd0;
         k_r       <= 4'd0;
         cur_r     <= '0;
         a_r       <= '0;
         b_r       <= '0;
         side_r    <= '0;
         task_r    <= '0;
         start_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         ready_r   <= 1'b1;
      end else begin
         state_r  <= state_nx_s;
         k_r      <= k_nx_s;
         cur_r    <= cur_nx_s;
         in_pos_r <= in_pos_nx_s;
         if (accept_s) begin
            merge_r   <= bus.cmd_merge;
            n512_r    <= bus.cmd_n512;
            out_pos_r <= bus.cmd_out_pos;
            first_r   <= bus.cmd_first_stage;
            num_r     <= bus.cmd_num_stages;
            a_r       <= bus.cmd_addr_a;
            b_r       <= bus.cmd_addr_b;
            side_r    <= bus.cmd_side;
         end
         if (state_nx_s == SM_ISSUE) begin
            task_r <= pack_s;
         end
         start_r <= (state_nx_s == SM_ISSUE);
         busy_r  <= (state_nx_s != SM_IDLE);
         ready_r <= (state_nx_s == SM_IDLE);
         done_r  <= (state_nx_s == SM_FIN);
         err_r   <= (state_r == SM_CHECK) && reject_s;
      end
   end

   assign bus.cmd_ready = ready_r;
   assign bus.task_o    = task_r;
   assign bus.start_o   = start_r;
   assign bus.busy_o    = busy_r;
   assign bus.done_o    = done_r;
   assign bus.err_o     = err_r;

`ifdef SPLIT_MERGE_SEQ_PERF_EN
   logic [31:0] perf_r;

   // Busy-cycle counter; busy_o drops after done_o/err_o, which freezes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_r <= 32'd0;
      end else if (accept_s) begin
         perf_r <= 32'd0;
      end else if (busy_r && (perf_r != 32'hFFFF_FFFF)) begin
         perf_r <= perf_r + 32'd1;
      end else begin
         perf_r <= perf_r;
      end
   end

   assign perf_cycles = perf_r;
`endif

endmodule

// File: tb/tb_split_merge_task_seq.sv
// Directed bench for split_merge_task_seq: chains, rejects, handshake timing, mid-chain reset.
module tb_split_merge_task_seq;
   import split_merge_task_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   split_merge_task_seq_if sm_if ();
`ifdef SPLIT_MERGE_SEQ_PERF_EN
   logic [31:0] perf_cycles;
`endif

   split_merge_task_seq #(.SIDE_STRIDE(64), .MAX_STAGE(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sm_if)
`ifdef SPLIT_MERGE_SEQ_PERF_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;

   always @(posedge clk) begin
      if (sm_if.start_o) start_cnt <= start_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk_task(input logic [4:0] st, input logic [2:0] ty,
                                           input logic ip, input logic op,
                                           input mem_addr_t a0, input mem_addr_t a1, input mem_addr_t a2);
      return {12'h000, a0, a1, a2, st, ty, 2'b00, op, ip, 4'b0000};
   endfunction

   task automatic send_cmd(input logic mg, input logic n5, input logic [4:0] fs, input logic [3:0] ns,
                           input logic ip, input logic op, input mem_addr_t src,
                           input mem_addr_t a, input mem_addr_t b, input mem_addr_t sd);
      @(negedge clk);
      sm_if.cmd_merge       = mg;
      sm_if.cmd_n512        = n5;
      sm_if.cmd_first_stage = fs;
      sm_if.cmd_num_stages  = ns;
      sm_if.cmd_in_pos      = ip;
      sm_if.cmd_out_pos     = op;
      sm_if.cmd_src         = src;
      sm_if.cmd_addr_a      = a;
      sm_if.cmd_addr_b      = b;
      sm_if.cmd_side        = sd;
      sm_if.cmd_valid       = 1'b1;
      @(negedge clk);
      sm_if.cmd_valid       = 1'b0;
   endtask

   // done_i high for one cycle after `dly` cycles; returns mid-cycle after the sampling edge.
   task automatic pulse_done(input int dly);
      repeat (dly) @(negedge clk);
      sm_if.done_i = 1'b1;
      @(negedge clk);
      sm_if.done_i = 1'b0;
   endtask

   task automatic check_issue(input string tag, input logic [63:0] exp);
      check_val({tag, "_start"}, 64'(sm_if.start_o), 64'd1);
      check_val({tag, "_task"}, 64'(sm_if.task_o), exp);
   endtask

   logic        rj_merge [3] = '{1'b1, 1'b0, 1'b0};
   logic        rj_n512  [3] = '{1'b0, 1'b1, 1'b1};
   logic [4:0]  rj_first [3] = '{5'd7, 5'd1, 5'd4};
   logic [3:0]  rj_num   [3] = '{4'd2, 4'd3, 4'd0};

   initial begin
      int s0;
      int bad;
      logic [63:0] exp_t;

      sm_if.cmd_valid = 1'b0; sm_if.cmd_merge = 1'b0; sm_if.cmd_n512 = 1'b0;
      sm_if.cmd_first_stage = 5'd0; sm_if.cmd_num_stages = 4'd0;
      sm_if.cmd_in_pos = 1'b0; sm_if.cmd_out_pos = 1'b0;
      sm_if.cmd_src = '0; sm_if.cmd_addr_a = '0; sm_if.cmd_addr_b = '0; sm_if.cmd_side = '0;
      sm_if.done_i = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_ready", 64'(sm_if.cmd_ready), 64'd1);
      check_val("rst_start", 64'(sm_if.start_o), 64'd0);
      check_val("rst_busy",  64'(sm_if.busy_o), 64'd0);
      check_val("rst_done",  64'(sm_if.done_o), 64'd0);
      check_val("rst_err",   64'(sm_if.err_o), 64'd0);
      check_val("rst_task",  64'(sm_if.task_o), 64'd0);
      rst = 1'b0;

      // spurious done_i in IDLE
      s0 = start_cnt;
      pulse_done(1);
      @(negedge clk);
      check_val("idle_done_nostart", 64'(start_cnt - s0), 64'd0);
      check_val("idle_done_ready", 64'(sm_if.cmd_ready), 64'd1);
      check_val("idle_done_busy", 64'(sm_if.busy_o), 64'd0);

      // split chain N512 8,7,6
      s0 = start_cnt;
      send_cmd(1'b0, 1'b1, 5'd8, 4'd3, 1'b1, 1'b0, 12'h000, 12'h100, 12'h200, 12'h300);
      check_val("split_check_busy", 64'(sm_if.busy_o), 64'd1);
      check_val("split_check_nostart", 64'(sm_if.start_o), 64'd0);
      @(negedge clk);
      check_issue("split_t0", mk_task(5'd8, 3'd4, 1'b1, 1'b0, 12'h000, 12'h100, 12'h300));
      pulse_done(3);
      check_issue("split_t1", mk_task(5'd7, 3'd4, 1'b0, 1'b0, 12'h100, 12'h200, 12'h340));
      pulse_done(2);
      check_issue("split_t2", mk_task(5'd6, 3'd4, 1'b0, 1'b0, 12'h200, 12'h100, 12'h380));
      pulse_done(1);
      check_val("split_done", 64'(sm_if.done_o), 64'd1);
      check_val("split_nstart", 64'(start_cnt - s0), 64'd3);
      @(negedge clk);
      check_val("split_done_pulse", 64'(sm_if.done_o), 64'd0);
      check_val("split_ready", 64'(sm_if.cmd_ready), 64'd1);
      check_val("split_idle_busy", 64'(sm_if.busy_o), 64'd0);

      // merge chain N256 5,6 with a long done_i wait and a command offered while busy
      s0 = start_cnt;
      send_cmd(1'b1, 1'b0, 5'd5, 4'd2, 1'b0, 1'b1, 12'h080, 12'h100, 12'h200, 12'h300);
      @(negedge clk);
      exp_t = mk_task(5'd5, 3'd3, 1'b0, 1'b1, 12'h080, 12'h340, 12'h100);
      check_issue("merge_t0", exp_t);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sm_if.task_o !== exp_t[TASK_REDUCE_BW-1:0]) bad++;
         if (sm_if.start_o) bad++;
         if (i == 5) begin
            sm_if.cmd_merge = 1'b0; sm_if.cmd_n512 = 1'b1;
            sm_if.cmd_first_stage = 5'd8; sm_if.cmd_num_stages = 4'd1;
            sm_if.cmd_src = 12'hFFF;
            sm_if.cmd_valid = 1'b1;
         end
         if (i == 15) begin
            check_val("busy_ready_low", 64'(sm_if.cmd_ready), 64'd0);
            sm_if.cmd_valid = 1'b0;
         end
      end
      check_val("hold_stable", 64'(bad), 64'd0);
      check_val("hold_one_start", 64'(start_cnt - s0), 64'd1);
      pulse_done(1);
      check_issue("merge_t1", mk_task(5'd6, 3'd3, 1'b1, 1'b1, 12'h100, 12'h300, 12'h200));
      pulse_done(4);
      check_val("merge_done", 64'(sm_if.done_o), 64'd1);
      check_val("merge_nstart", 64'(start_cnt - s0), 64'd2);
      @(negedge clk);

      // rejected commands
      for (int r = 0; r < 3; r++) begin
         s0 = start_cnt;
         send_cmd(rj_merge[r], rj_n512[r], rj_first[r], rj_num[r], 1'b0, 1'b0,
                  12'h010, 12'h020, 12'h030, 12'h040);
         @(negedge clk);
         check_val($sformatf("rej%0d_err", r), 64'(sm_if.err_o), 64'd1);
         check_val($sformatf("rej%0d_ready", r), 64'(sm_if.cmd_ready), 64'd1);
         @(negedge clk);
         check_val($sformatf("rej%0d_err_pulse", r), 64'(sm_if.err_o), 64'd0);
         check_val($sformatf("rej%0d_nostart", r), 64'(start_cnt - s0), 64'd0);
      end

      // done_i held through accept and CHECK must be ignored
      sm_if.done_i = 1'b1;
      send_cmd(1'b0, 1'b0, 5'd0, 4'd1, 1'b1, 1'b1, 12'h555, 12'h0AA, 12'h0BB, 12'h123);
      @(negedge clk);
      sm_if.done_i = 1'b0;
      check_issue("single_t0", mk_task(5'd0, 3'd2, 1'b1, 1'b1, 12'h555, 12'h0AA, 12'h123));
      repeat (3) @(negedge clk);
      check_val("single_still_busy", 64'(sm_if.busy_o), 64'd1);
      check_val("single_no_early_done", 64'(sm_if.done_o), 64'd0);
      pulse_done(1);
      check_val("single_done", 64'(sm_if.done_o), 64'd1);
      @(negedge clk);

      // reset during WAIT of the second task
      send_cmd(1'b0, 1'b1, 5'd8, 4'd3, 1'b1, 1'b0, 12'h000, 12'h100, 12'h200, 12'h300);
      @(negedge clk);
      pulse_done(2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("mrst_start", 64'(sm_if.start_o), 64'd0);
      check_val("mrst_busy",  64'(sm_if.busy_o), 64'd0);
      check_val("mrst_ready", 64'(sm_if.cmd_ready), 64'd1);
      check_val("mrst_task",  64'(sm_if.task_o), 64'd0);
      rst = 1'b0;

      // fresh chain after reset; side address wraps
      send_cmd(1'b0, 1'b0, 5'd3, 4'd2, 1'b0, 1'b1, 12'hABC, 12'h010, 12'h020, 12'hFC0);
      @(negedge clk);
      check_issue("fresh_t0", mk_task(5'd3, 3'd2, 1'b0, 1'b1, 12'hABC, 12'h010, 12'hFC0));
      pulse_done(1);
      check_issue("fresh_t1", mk_task(5'd2, 3'd2, 1'b1, 1'b1, 12'h010, 12'h020, 12'h000));
      pulse_done(1);
      check_val("fresh_done", 64'(sm_if.done_o), 64'd1);
      @(negedge clk);

`ifdef SPLIT_MERGE_SEQ_PERF_EN
      send_cmd(1'b0, 1'b1, 5'd5, 4'd1, 1'b0, 1'b0, 12'h001, 12'h002, 12'h003, 12'h004);
      @(negedge clk);
      check_val("perf_start", 64'(sm_if.start_o), 64'd1);
      pulse_done(10);
      check_val("perf_done", 64'(sm_if.done_o), 64'd1);
      @(negedge clk);
      check_val("perf_count", 64'(perf_cycles), 64'd13);
      repeat (5) @(negedge clk);
      check_val("perf_frozen", 64'(perf_cycles), 64'd13);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
